// File: rtl/div.sv
// Sequential restoring divider: one quotient bit per clock, start/fin handshake.
//
//  state  | meaning
//  -------+---------------------------------------------------------------
//  S_IDLE | waiting for start; Q/R/dz hold the last result
//  S_RUN  | DW shift/compare/subtract iterations, one per edge
//  S_DONE | fin high for this single cycle, then back to S_IDLE
module div #(
    parameter int DW = 16,
    parameter int W  = 8
) (
    input  logic          ck,
    input  logic          rst_n,
    input  logic [DW-1:0] N,
    input  logic [W-1:0]  D,
    input  logic          start,
    output logic [DW-1:0] Q,
    output logic [W-1:0]  R,
    output logic          fin,
    output logic          busy,
    output logic          dz
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] n_sh_q, n_sh_d;
    logic [W-1:0]  d_q, d_d;
    logic [W-1:0]  rem_q, rem_d;
    logic [DW-1:0] quo_q, quo_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] q_q, q_d;
    logic [W-1:0]  r_q, r_d;
    logic          dz_q, dz_d;
    logic          fin_q, fin_d;

    // Trial value is W+1 bits wide so the compare cannot overflow; after a
    // successful subtract the difference is below D and always fits in W bits.
    logic [W:0]    p;
    logic          ge;

    // Next-state, datapath step and result capture.
    always_comb begin
        state_d = state_q;
        n_sh_d  = n_sh_q;
        d_d     = d_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        fin_d   = 1'b0;
        p       = {rem_q, n_sh_q[DW-1]};
        ge      = (p >= {1'b0, d_q});

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (D != '0) begin
                        n_sh_d  = N;
                        d_d     = D;
                        rem_d   = '0;
                        quo_d   = '0;
                        cnt_d   = '0;
                        dz_d    = 1'b0;
                        state_d = S_RUN;
                    end else begin
                        q_d     = '1;
                        r_d     = '0;
                        dz_d    = 1'b1;
                        fin_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                n_sh_d = n_sh_q << 1;
                quo_d  = (quo_q << 1) | DW'(ge);
                rem_d  = ge ? W'(p - {1'b0, d_q}) : p[W-1:0];
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(DW - 1)) begin
                    q_d     = quo_d;
                    r_d     = rem_d;
                    fin_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight operation.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            n_sh_q  <= '0;
            d_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_sh_q  <= n_sh_d;
            d_q     <= d_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
            fin_q   <= fin_d;
        end
    end

    assign Q    = q_q;
    assign R    = r_q;
    assign fin  = fin_q;
    assign dz   = dz_q;
    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_div.sv
// Directed and random checks for the sequential divider.
module tb_div;

    logic        ck = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] N;
    logic [7:0]  D;
    logic [15:0] Q;
    logic [7:0]  R;
    logic        fin;
    logic        busy;
    logic        dz;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] n;
        logic [7:0]  d;
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
    } vec_t;

    vec_t vecs[9];

    div #(.DW(16), .W(8)) dut (
        .ck    (ck),
        .rst_n (rst_n),
        .N     (N),
        .D     (D),
        .start (start),
        .Q     (Q),
        .R     (R),
        .fin   (fin),
        .busy  (busy),
        .dz    (dz)
    );

    always #5 ck = ~ck;

    always @(posedge ck) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Runs one operation with a single start pulse and checks latency, busy and result.
    task automatic do_op(input vec_t v);
        int t;
        int lat;
        int busy_low;
        @(negedge ck);
        N = v.n; D = v.d; start = 1'b1;
        @(negedge ck);
        start = 1'b0;
        t = cyc;
        lat = -1;
        busy_low = 0;
        for (int k = 0; k < 40; k++) begin
            if (!busy) busy_low++;
            if (fin) begin
                lat = cyc - t;
                break;
            end
            @(negedge ck);
        end
        chk("latency", lat, v.dz ? 0 : 16);
        chk("busy_during", busy_low, 0);
        chk("Q", {16'h0, Q}, {16'h0, v.q});
        chk("R", {24'h0, R}, {24'h0, v.r});
        chk("dz", {31'h0, dz}, {31'h0, v.dz});
        @(negedge ck);
        chk("fin_one_cycle", {31'h0, fin}, 32'h0);
        chk("busy_after", {31'h0, busy}, 32'h0);
        chk("Q_held", {16'h0, Q}, {16'h0, v.q});
    endtask

    initial begin
        int t;
        int nfin;
        int prev_fin;
        int exp_sp;
        logic [15:0] cur_n;
        logic [7:0]  cur_d;

        vecs[0] = '{16'd200,   8'd7,   16'd28,     8'd4,   1'b0};
        vecs[1] = '{16'hFFFF,  8'd1,   16'hFFFF,   8'd0,   1'b0};
        vecs[2] = '{16'd5,     8'd9,   16'd0,      8'd5,   1'b0};
        vecs[3] = '{16'hFFFF,  8'hFF,  16'h0101,   8'd0,   1'b0};
        vecs[4] = '{16'd1234,  8'd0,   16'hFFFF,   8'd0,   1'b1};
        vecs[5] = '{16'd10,    8'd3,   16'd3,      8'd1,   1'b0};
        vecs[6] = '{16'd0,     8'd5,   16'd0,      8'd0,   1'b0};
        vecs[7] = '{16'd1000,  8'd255, 16'd3,      8'd235, 1'b0};
        vecs[8] = '{16'd65535, 8'd200, 16'd327,    8'd135, 1'b0};

        rst_n = 1'b0; start = 1'b0; N = '0; D = '0;
        repeat (3) @(negedge ck);
        chk("rst_Q", {16'h0, Q}, 32'h0);
        chk("rst_R", {24'h0, R}, 32'h0);
        chk("rst_fin", {31'h0, fin}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_dz", {31'h0, dz}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge ck);

        for (int i = 0; i < 9; i++) do_op(vecs[i]);

        // A start pulse mid-operation must be ignored, not queued.
        @(negedge ck);
        N = 16'd100; D = 8'd3; start = 1'b1;
        @(negedge ck);
        start = 1'b0;
        t = cyc;
        while (cyc < t + 4) @(negedge ck);
        N = 16'd9; D = 8'd9; start = 1'b1;
        @(negedge ck);
        start = 1'b0;
        chk("busy_ign", {31'h0, busy}, 32'h1);
        nfin = 0;
        for (int k = 0; k < 40 && nfin == 0; k++) begin
            if (fin) nfin = cyc - t;
            else @(negedge ck);
        end
        chk("ign_latency", nfin, 16);
        chk("ign_Q", {16'h0, Q}, 32'd33);
        chk("ign_R", {24'h0, R}, 32'd1);
        nfin = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge ck);
            if (fin) nfin++;
        end
        chk("ign_no_second_fin", nfin, 0);

        // Asynchronous reset in the middle of an operation.
        @(negedge ck);
        N = 16'd200; D = 8'd7; start = 1'b1;
        @(negedge ck);
        start = 1'b0;
        t = cyc;
        while (cyc < t + 8) @(negedge ck);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_Q", {16'h0, Q}, 32'h0);
        chk("arst_R", {24'h0, R}, 32'h0);
        chk("arst_fin", {31'h0, fin}, 32'h0);
        chk("arst_busy", {31'h0, busy}, 32'h0);
        chk("arst_dz", {31'h0, dz}, 32'h0);
        repeat (3) @(negedge ck);
        rst_n = 1'b1;
        nfin = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge ck);
            if (fin) nfin++;
        end
        chk("arst_no_fin", nfin, 0);
        do_op('{16'd50, 8'd5, 16'd10, 8'd0, 1'b0});

        // Random back-to-back operations with start held high. A normal op
        // completes every 18 edges; a divide-by-zero completes on its accept
        // edge, so it follows the previous fin by two edges.
        @(negedge ck);
        cur_n = 16'($urandom);
        cur_d = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
        N = cur_n; D = cur_d; start = 1'b1;
        nfin = 0;
        prev_fin = -1;
        exp_sp = 0;
        for (int c = 0; c < 30000 && nfin < 1000; c++) begin
            @(negedge ck);
            if (fin) begin
                if (cur_d == 8'd0) begin
                    chk("rnd_Q", {16'h0, Q}, 32'hFFFF);
                    chk("rnd_R", {24'h0, R}, 32'h0);
                    chk("rnd_dz", {31'h0, dz}, 32'h1);
                end else begin
                    chk("rnd_Q", {16'h0, Q}, {16'h0, cur_n / {8'h0, cur_d}});
                    chk("rnd_R", {24'h0, R}, {16'h0, cur_n % {8'h0, cur_d}});
                    chk("rnd_dz", {31'h0, dz}, 32'h0);
                end
                if (prev_fin >= 0) chk("rnd_spacing", cyc - prev_fin, exp_sp);
                prev_fin = cyc;
                nfin++;
                cur_n = 16'($urandom);
                cur_d = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
                exp_sp = (cur_d == 8'd0) ? 2 : 18;
                N = cur_n; D = cur_d;
            end
        end
        chk("rnd_count", nfin, 1000);
        start = 1'b0;
        repeat (25) @(negedge ck);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
